// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - Stepped up-counter bounded by [min, max] with wrap-to-min and overflow strobe
module wrap_counter #(
  parameter int nbits = 8,
  parameter int min   = 0,
  parameter int max   = 255,
  parameter int step  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [nbits-1:0] count,
  output logic             overflow
);

  // Sum width covers both the count and a full 32-bit step so count + step never truncates.
  localparam int sum_w = ((nbits > 32) ? nbits : 32) + 2;

  localparam bit max_too_big = (nbits >= 1) && (nbits < 32) &&
                               (longint'(max) >= (longint'(1) << nbits));
  localparam bit params_ok   = (nbits >= 1) && (step >= 1) && (min <= max) && !max_too_big;

  generate
    if (params_ok) begin : g_counter
      logic [sum_w-1:0] sum;
      logic             wrap;

      assign sum      = sum_w'(count) + sum_w'(step);
      assign wrap     = (sum > sum_w'(max));
      assign overflow = en && !clr && !rst && wrap;

      // Excess past max is dropped on wrap, so every period restarts exactly at min.
      always_ff @(posedge clk) begin
        if (rst) begin
          count <= nbits'(min);
        end else if (clr) begin
          count <= nbits'(min);
        end else if (en) begin
          count <= wrap ? nbits'(min) : sum[nbits-1:0];
        end
      end
    end else begin : g_invalid
      initial begin
        $display("counter: Invalid parameters");
        $finish(1);
      end
      assign count    = '0;
      assign overflow = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_wrap_counter.sv
// tb/tb_wrap_counter.sv - Directed scoreboard bench for wrap_counter across several parameter sets
module tb_wrap_counter;

  logic clk;
  logic rst;
  logic clr_a, en_a, en_b, en_c, en_d, en_div;
  logic [7:0] count_a, count_ch;
  logic [3:0] count_b, count_c;
  logic [0:0] count_d;
  logic [1:0] count_div;
  logic ovf_a, ovf_b, ovf_c, ovf_d, ovf_div, ovf_ch;

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int ea;

  int seq_b[4] = '{3, 5, 7, 9};
  int seq_c[4] = '{0, 3, 6, 9};
  bit pat_d[4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  wrap_counter u_a (
    .clk(clk), .rst(rst), .clr(clr_a), .en(en_a), .count(count_a), .overflow(ovf_a)
  );
  wrap_counter #(.nbits(4), .min(3), .max(9), .step(2)) u_b (
    .clk(clk), .rst(rst), .clr(1'b0), .en(en_b), .count(count_b), .overflow(ovf_b)
  );
  wrap_counter #(.nbits(4), .min(0), .max(10), .step(3)) u_c (
    .clk(clk), .rst(rst), .clr(1'b0), .en(en_c), .count(count_c), .overflow(ovf_c)
  );
  wrap_counter #(.nbits(1), .min(0), .max(0), .step(1)) u_d (
    .clk(clk), .rst(rst), .clr(1'b0), .en(en_d), .count(count_d), .overflow(ovf_d)
  );
  wrap_counter #(.nbits(2), .min(0), .max(3), .step(1)) u_div (
    .clk(clk), .rst(rst), .clr(1'b0), .en(en_div), .count(count_div), .overflow(ovf_div)
  );
  wrap_counter u_ch (
    .clk(clk), .rst(rst), .clr(1'b0), .en(ovf_div), .count(count_ch), .overflow(ovf_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One enabled cycle on the default counter with its expected next value queued before the edge.
  task automatic run_a(input int n);
    for (int k = 0; k < n; k++) begin
      en_a = 1'b1;
      #1;
      chk("ovf_a_run", ovf_a, (ea == 255));
      ea = (ea == 255) ? 0 : ea + 1;
      exp_q.push_back(ea);
      tick();
      chk("cnt_a_run", count_a, exp_q.pop_front());
    end
  endtask

  initial begin
    rst = 1'b1; clr_a = 1'b0;
    en_a = 1'b1; en_b = 1'b0; en_c = 1'b0; en_d = 1'b0; en_div = 1'b0;
    #1;
    chk("ovf_a_in_rst", ovf_a, 0);
    en_a = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_cnt_a", count_a, 0);
    chk("rst_cnt_b", count_b, 3);
    chk("rst_cnt_c", count_c, 0);
    chk("rst_cnt_d", count_d, 0);
    chk("rst_cnt_div", count_div, 0);
    chk("rst_cnt_ch", count_ch, 0);

    // Free-running phase: all counters enabled, u_d sees the 1,1,0,1 enable pattern.
    for (int i = 0; i < 1030; i++) begin
      en_a = 1'b1; en_b = 1'b1; en_c = 1'b1; en_div = 1'b1; en_d = pat_d[i % 4];
      #1;
      chk("ovf_a", ovf_a, ((i % 256) == 255));
      chk("ovf_b", ovf_b, ((i % 4) == 3));
      chk("ovf_c", ovf_c, ((i % 4) == 3));
      chk("ovf_d", ovf_d, pat_d[i % 4]);
      chk("ovf_div", ovf_div, ((i % 4) == 3));
      chk("ovf_ch", ovf_ch, (i == 1023));
      exp_q.push_back((i + 1) % 256);
      exp_q.push_back(seq_b[(i + 1) % 4]);
      exp_q.push_back(seq_c[(i + 1) % 4]);
      exp_q.push_back(0);
      exp_q.push_back((i + 1) % 4);
      exp_q.push_back(((i + 1) / 4) % 256);
      tick();
      chk("cnt_a", count_a, exp_q.pop_front());
      chk("cnt_b", count_b, exp_q.pop_front());
      chk("cnt_c", count_c, exp_q.pop_front());
      chk("cnt_d", count_d, exp_q.pop_front());
      chk("cnt_div", count_div, exp_q.pop_front());
      chk("cnt_ch", count_ch, exp_q.pop_front());
    end

    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0; en_d = 1'b0; en_div = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ea = 0;

    run_a(100);
    chk("cnt_a_at_100", count_a, 100);
    clr_a = 1'b1; en_a = 1'b1;
    #1;
    chk("ovf_a_clr", ovf_a, 0);
    tick();
    clr_a = 1'b0;
    chk("cnt_a_after_clr", count_a, 0);
    ea = 0;

    run_a(255);
    clr_a = 1'b1; en_a = 1'b1;
    #1;
    chk("ovf_a_clr_at_max", ovf_a, 0);
    tick();
    clr_a = 1'b0;
    chk("cnt_a_clr_at_max", count_a, 0);
    ea = 0;

    run_a(40);
    chk("cnt_a_at_40", count_a, 40);
    rst = 1'b1; en_a = 1'b1;
    #1;
    chk("ovf_a_rst", ovf_a, 0);
    tick();
    rst = 1'b0;
    chk("cnt_a_after_rst", count_a, 0);
    ea = 0;

    run_a(7);
    en_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("ovf_a_hold", ovf_a, 0);
      tick();
      chk("cnt_a_hold", count_a, 7);
    end

    run_a(248);
    en_a = 1'b0;
    #1;
    chk("ovf_a_hold_max", ovf_a, 0);
    tick();
    chk("cnt_a_hold_max", count_a, 255);
    en_a = 1'b1;
    #1;
    chk("ovf_a_resume_max", ovf_a, 1);
    tick();
    chk("cnt_a_resume_wrap", count_a, 0);
    en_a = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
